// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus: requester side, ROM port,
// response strobe and per-frame stall statistics.
interface sprite_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 12,
  parameter int DW   = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic               rom_en;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic               frame_start;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic [15:0]        stall_cnt;

  modport master (
    output req, addr, rom_data, frame_start,
    input  gnt, rom_en, rom_addr,
    input  rsp_valid, rsp_id, rsp_data, stall_cnt
  );

  modport slave (
    input  req, addr, rom_data, frame_start,
    output gnt, rom_en, rom_addr,
    output rsp_valid, rsp_id, rsp_data, stall_cnt
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one sync-read sprite ROM port: requester 0 (VGA) has
// strict priority, the others split leftover cycles round-robin.
module sprite_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int ROM_LAT = 1
) (
  input logic clk,
  input logic reset,
  sprite_rom_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] lp_req;
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] pick_set;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gid;
  logic [AW-1:0]   raddr;
  logic [IDW-1:0]  rr_ptr;
  logic            stall_now;
  logic [15:0]     live;
  logic [15:0]     stall_q;
  logic [ROM_LAT-1:0] vld;
  logic [IDW-1:0]  pid [ROM_LAT];

  assign lp_req = {bus.req[NREQ-1:1], 1'b0};

  // Prefer requests at or above rr_ptr; else wrap to the lowest one.
  always_comb begin
    hi_req = '0;
    for (int i = 1; i < NREQ; i++)
      hi_req[i] = lp_req[i] && (i >= int'(rr_ptr));
    pick_set = (|hi_req) ? hi_req : lp_req;
  end

  always_comb begin
    gnt = '0;
    gid = '0;
    if (bus.req[0]) begin
      gnt[0] = 1'b1;
    end else begin
      for (int i = NREQ - 1; i >= 1; i--) begin
        if (pick_set[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          gid    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    raddr = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) raddr = bus.addr[i*AW +: AW];
  end

  assign stall_now = |(lp_req & ~gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= IDW'(1);
    end else if (|gnt && !gnt[0]) begin
      rr_ptr <= (int'(gid) == NREQ - 1) ?
                IDW'(1) : gid + IDW'(1);
    end
  end

  // A stall in the frame_start cycle belongs to the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live    <= '0;
      stall_q <= '0;
    end else if (bus.frame_start) begin
      stall_q <= live;
      live    <= {15'd0, stall_now};
    end else if (stall_now && live != 16'hFFFF) begin
      live <= live + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < ROM_LAT; k++) pid[k] <= '0;
    end else begin
      vld[0] <= |gnt;
      pid[0] <= gid;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld[k] <= vld[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rom_en    = |gnt;
  assign bus.rom_addr  = raddr;
  assign bus.rsp_valid = vld[ROM_LAT-1];
  assign bus.rsp_id    = pid[ROM_LAT-1];
  assign bus.rsp_data  = vld[ROM_LAT-1] ? bus.rom_data : '0;
  assign bus.stall_cnt = stall_q;
endmodule
